// File: rtl/wave_store.sv
// wave_store: triggered sample-capture ring buffer feeding the LCD waveform renderer.
// Optional macro AUTO_TRIG_EN forces a trigger after AUTO_TIMEOUT armed samples.
module wave_store #(
    parameter int ADDR_W       = 9,
    parameter int DEPTH        = 400,
    parameter int PRE_TRIG     = 200,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        ad_data,
    input  logic              ad_valid,
    input  logic              run,
    input  logic [7:0]        trig_level,
    input  logic              trig_edge,
    input  logic              wave_data_req,
    input  logic [ADDR_W-1:0] wave_addr,
    input  logic              wr_over,
    output logic [7:0]        wave_data,
    output logic              frame_valid,
    output logic              trig_auto
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] PRE_N    = ADDR_W'(PRE_TRIG);
    localparam logic [ADDR_W-1:0] PRE_LAST = ADDR_W'(PRE_TRIG - 1);
    localparam logic [ADDR_W-1:0] POST_N   = ADDR_W'(DEPTH - PRE_TRIG);
    localparam logic [ADDR_W:0]   DEP      = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, PRE, ARM, POST, HOLD} state_t;

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, pre_cnt, post_cnt, start_ptr, start_nxt, rd_addr;
    logic [ADDR_W:0]   rd_sum;
    logic [7:0]        prev;
    logic              we, hit, timeout;

`ifdef AUTO_TRIG_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
    logic [TO_W-1:0] to_cnt;
    assign timeout = to_cnt == TO_W'(AUTO_TIMEOUT);
`else
    assign timeout   = 1'b0;
    assign trig_auto = 1'b0;
`endif

    assign we        = ad_valid && (state == PRE || state == ARM || state == POST);
    assign hit       = trig_edge ? (prev < trig_level && ad_data >= trig_level)
                                 : (prev > trig_level && ad_data <= trig_level);
    assign start_nxt = (wr_ptr >= PRE_N) ? wr_ptr - PRE_N : wr_ptr + POST_N;
    // wave_addr may exceed DEPTH, so a full modulo keeps the read inside the ring
    assign rd_sum    = {1'b0, start_ptr} + {1'b0, wave_addr};
    assign rd_addr   = ADDR_W'(rd_sum % DEP);

    always_ff @(posedge clk)
        if (we) mem[wr_ptr[AW-1:0]] <= ad_data;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) wave_data <= '0;
        else if (wave_data_req) wave_data <= mem[rd_addr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            start_ptr   <= '0;
            prev        <= '0;
            frame_valid <= 1'b0;
`ifdef AUTO_TRIG_EN
            to_cnt      <= '0;
            trig_auto   <= 1'b0;
`endif
        end else begin
            if (we) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                prev   <= ad_data;
            end
            case (state)
                IDLE: if (run) begin
                    state   <= PRE;
                    pre_cnt <= '0;
                end
                PRE: if (ad_valid) begin
                    pre_cnt <= pre_cnt + 1'b1;
                    if (pre_cnt == PRE_LAST) begin
                        state <= ARM;
`ifdef AUTO_TRIG_EN
                        to_cnt <= '0;
`endif
                    end
                end
                ARM: if (ad_valid) begin
                    // the current sample is the trigger sample and counts as the first post write
                    if (hit || timeout) begin
                        start_ptr   <= start_nxt;
                        post_cnt    <= ADDR_W'(1);
                        state       <= (DEPTH - PRE_TRIG == 1) ? HOLD : POST;
                        frame_valid <= (DEPTH - PRE_TRIG == 1);
`ifdef AUTO_TRIG_EN
                        trig_auto   <= !hit;
                    end else begin
                        to_cnt      <= to_cnt + 1'b1;
`endif
                    end
                end
                POST: if (ad_valid) begin
                    post_cnt <= post_cnt + 1'b1;
                    if (post_cnt + 1'b1 == POST_N) begin
                        state       <= HOLD;
                        frame_valid <= 1'b1;
                    end
                end
                HOLD: if (wr_over) begin
                    frame_valid <= 1'b0;
                    pre_cnt     <= '0;
                    state       <= run ? PRE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_wave_store.sv
// tb_wave_store: directed checks of capture, trigger placement and read path (DEPTH=16, PRE_TRIG=4).
module tb_wave_store;
    logic       clk = 0, rst_n = 0, ad_valid = 0, run = 0, trig_edge = 1;
    logic       wave_data_req = 0, wr_over = 0;
    logic [7:0] ad_data = 0, trig_level = 100;
    logic [8:0] wave_addr = 0;
    logic [7:0] wave_data;
    logic       frame_valid, trig_auto;
    int         errors = 0, checks = 0;

    typedef struct {
        logic       req;
        logic [8:0] addr;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs [20];

    wave_store #(.ADDR_W(9), .DEPTH(16), .PRE_TRIG(4), .AUTO_TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .ad_data(ad_data), .ad_valid(ad_valid), .run(run),
        .trig_level(trig_level), .trig_edge(trig_edge), .wave_data_req(wave_data_req),
        .wave_addr(wave_addr), .wr_over(wr_over), .wave_data(wave_data),
        .frame_valid(frame_valid), .trig_auto(trig_auto)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input int first, input int step, input int maxn, output int n);
        n = 0;
        for (int k = 0; k < maxn; k++) begin
            ad_data  = 8'(first + step * k);
            ad_valid = 1;
            tick();
            n = k + 1;
            if (frame_valid) break;
        end
        ad_data = 8'hEE;
    endtask

    task automatic rd(input int a, input int e, input string name);
        wave_addr     = 9'(a);
        wave_data_req = 1;
        tick();
        wave_data_req = 0;
        chk(name, wave_data, e);
    endtask

    task automatic pulse_over(input string name);
        wr_over  = 1;
        ad_valid = 1;
        ad_data  = 8'h55;
        tick();
        wr_over = 0;
        chk(name, frame_valid, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic seen;
        for (int i = 0; i < 16; i++) vecs[i] = '{1'b1, 9'(i), 8'(60 + 10 * i)};
        vecs[16] = '{1'b0, 9'd3,   8'd210};
        vecs[17] = '{1'b1, 9'd20,  8'd100};
        vecs[18] = '{1'b1, 9'd511, 8'd210};
        vecs[19] = '{1'b1, 9'd16,  8'd60};

        repeat (2) tick();
        chk("reset wave_data", wave_data, 0);
        chk("reset frame_valid", frame_valid, 0);
        chk("reset trig_auto", trig_auto, 0);

        rst_n = 1;
        run   = 1;
        tick();
        capture(0, 10, 40, n);
        chk("rise samples to frame", n, 22);
        for (int i = 0; i < 20; i++) begin
            wave_addr     = vecs[i].addr;
            wave_data_req = vecs[i].req;
            tick();
            chk($sformatf("rise vec %0d", i), wave_data, vecs[i].exp);
        end
        wave_data_req = 0;
        chk("rise trig_auto", trig_auto, 0);

        trig_edge  = 0;
        trig_level = 50;
        pulse_over("over clears frame_valid");
        capture(200, -10, 60, n);
        chk("fall samples to frame", n, 27);
        rd(4, 50, "fall idx4");
        rd(0, 90, "fall idx0");
        rd(5, 40, "fall idx5");
        rd(10, 246, "fall idx10");

        trig_edge  = 1;
        trig_level = 100;
        pulse_over("over before flat");
`ifdef AUTO_TRIG_EN
        capture(100, 0, 100, n);
        chk("auto samples to frame", n, 24);
        chk("auto trig_auto", trig_auto, 1);
        rd(4, 100, "auto idx4");
        rd(0, 100, "auto idx0");
`else
        seen = 0;
        for (int k = 0; k < 10000; k++) begin
            ad_data  = 100;
            ad_valid = 1;
            tick();
            seen |= frame_valid;
        end
        chk("flat never triggers", seen, 0);
        ad_data = 99;
        tick();
        ad_data = 100;
        tick();
        capture(120, 1, 20, n);
        chk("after flat post samples", n, 11);
        chk("after flat trig_auto", trig_auto, 0);
        rd(3, 99, "after flat idx3");
        rd(4, 100, "after flat idx4");
        rd(5, 120, "after flat idx5");
        rd(15, 130, "after flat idx15");
        rd(0, 100, "after flat idx0");
`endif

        pulse_over("over before reset test");
        for (int k = 0; k < 14; k++) begin
            ad_data  = 8'(10 * k);
            ad_valid = 1;
            tick();
        end
        #3 rst_n = 0;
        #1;
        chk("async reset wave_data", wave_data, 0);
        chk("async reset frame_valid", frame_valid, 0);
        chk("async reset trig_auto", trig_auto, 0);
        run      = 0;
        ad_valid = 0;
        tick();
        rst_n = 1;
        run   = 1;
        tick();
        capture(0, 10, 40, n);
        chk("post-reset samples to frame", n, 22);
        rd(0, 60, "post-reset idx0");
        rd(4, 100, "post-reset idx4");
        rd(15, 210, "post-reset idx15");

        pulse_over("over before wrap");
        run = 0;
        capture(10, 10, 40, n);
        chk("wrap samples to frame", n, 21);
        for (int i = 0; i < 16; i++) rd(i, 60 + 10 * i, $sformatf("wrap idx%0d", i));

        pulse_over("over to idle");
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            ad_data  = 8'(5 * k);
            ad_valid = 1;
            tick();
            seen |= frame_valid;
        end
        chk("idle no capture", seen, 0);
        run = 1;
        ad_valid = 0;
        tick();
        capture(0, 10, 40, n);
        chk("rearm samples to frame", n, 22);
        rd(4, 100, "rearm idx4");
        #3 rst_n = 0;
        #1;
        chk("reset in hold frame_valid", frame_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
